// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
// funct3 codes, FSM state encoding and iteration count.
package muldiv_pkg;
    localparam logic [2:0] FN_MUL    = 3'b000;
    localparam logic [2:0] FN_MULH   = 3'b001;
    localparam logic [2:0] FN_MULHSU = 3'b010;
    localparam logic [2:0] FN_MULHU  = 3'b011;
    localparam logic [2:0] FN_DIV    = 3'b100;
    localparam logic [2:0] FN_DIVU   = 3'b101;
    localparam logic [2:0] FN_REM    = 3'b110;
    localparam logic [2:0] FN_REMU   = 3'b111;

    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_if.sv
// Register-file side bus of the multiply/divide unit: operand request in, write-port result out.
// The core drives the master side; start is only honoured while busy is low.
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic            wrt_en;
    logic [4:0]      wrt_addr;
    logic [XLEN-1:0] wrt_data;

    modport master (output start, funct3, rs1_data, rs2_data, rd_addr,
                    input  busy, done, wrt_en, wrt_addr, wrt_data);
    modport slave  (input  start, funct3, rs1_data, rs2_data, rd_addr,
                    output busy, done, wrt_en, wrt_addr, wrt_data);
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned engine: shift-add multiply or restoring divide, one bit per step, 32 steps.
// No backpressure; the top FSM issues init once and then step every cycle until last.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;

    // Multiply: {hi,lo} with multiplier in lo, add into hi then shift right.
    // Divide: {remainder, dividend}; shift left and try to subtract the divisor.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_part = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = div_part >= {1'b0, opb_q};
        div_diff = div_part[XLEN-1:0] - opb_q;
        if (is_div) begin
            acc_d = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else if (init) begin
            acc_q <= {{XLEN{1'b0}}, a_mag};
            opb_q <= b_mag;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CNT_W'(ITER_CNT - 1));
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: fixed 33-cycle latency from start edge to the done/write edge.
// Holds busy while computing; start during busy is ignored, result is a one-cycle register write.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    state_t            state_q, state_d;
    logic              init, step, last;
    logic              a_signed, b_signed;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   quo, rem, result;

    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              a_neg_q, b_neg_q, div_zero_q, ovf_q;
    logic [XLEN-1:0]   dividend_q;
    logic              done_q, wrt_en_q;
    logic [4:0]        wrt_addr_q;
    logic [XLEN-1:0]   wrt_data_q;

    always_comb begin
        a_signed = bus.funct3 inside {FN_MUL, FN_MULH, FN_MULHSU, FN_DIV, FN_REM};
        b_signed = bus.funct3 inside {FN_MUL, FN_MULH, FN_DIV, FN_REM};
        a_mag    = (a_signed && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
        b_mag    = (b_signed && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
    end

    always_comb begin
        state_d = state_q;
        init    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                init    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .step   (step),
        .is_div (f3_q[2]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc),
        .last   (last)
    );

    // Sign fix-up on magnitudes; divide-by-zero and overflow override the engine result.
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
        quo  = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        case (f3_q)
            FN_MUL:           result = prod[XLEN-1:0];
            FN_DIV, FN_DIVU:  result = div_zero_q ? {XLEN{1'b1}} :
                                       ovf_q      ? {1'b1, {(XLEN-1){1'b0}}} :
                                       (a_neg_q ^ b_neg_q) ? -quo : quo;
            FN_REM, FN_REMU:  result = div_zero_q ? dividend_q :
                                       ovf_q      ? '0 :
                                       a_neg_q    ? -rem : rem;
            default:          result = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            f3_q       <= '0;
            rd_q       <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            dividend_q <= '0;
            done_q     <= 1'b0;
            wrt_en_q   <= 1'b0;
            wrt_addr_q <= '0;
            wrt_data_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= 1'b0;
            wrt_en_q <= 1'b0;
            if (init) begin
                f3_q       <= bus.funct3;
                rd_q       <= bus.rd_addr;
                a_neg_q    <= a_signed && bus.rs1_data[XLEN-1];
                b_neg_q    <= b_signed && bus.rs2_data[XLEN-1];
                div_zero_q <= (bus.rs2_data == '0);
                ovf_q      <= (bus.funct3 inside {FN_DIV, FN_REM}) &&
                              (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                              (bus.rs2_data == {XLEN{1'b1}});
                dividend_q <= bus.rs1_data;
            end
            if (state_q == FIN) begin
                done_q     <= 1'b1;
                wrt_en_q   <= (rd_q != 5'd0);
                wrt_addr_q <= rd_q;
                wrt_data_q <= result;
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.wrt_en   = wrt_en_q;
    assign bus.wrt_addr = wrt_addr_q;
    assign bus.wrt_data = wrt_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: stimulus pushes expected writes into a queue, a negedge monitor pops and compares.
// Expected results come from plain-arithmetic RV32M semantics.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wen;
        int          issue;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] hold_data = '0;
    logic [4:0]  hold_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (f)
            FN_MUL:    begin p = sa * sb; return p[31:0];  end
            FN_MULH:   begin p = sa * sb; return p[63:32]; end
            FN_MULHSU: begin p = sa * ub; return p[63:32]; end
            FN_MULHU:  begin p = ua * ub; return p[63:32]; end
            FN_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            FN_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            FN_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding request, 33 cycles after issue.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_data = '0;
            hold_addr = '0;
        end else if (bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no request outstanding (cycle %0d)", cyc);
                hold_data = bus.wrt_data;
                hold_addr = bus.wrt_addr;
            end else begin
                e = sb_q.pop_front();
                chk("wrt_data", bus.wrt_data, e.data);
                chk("wrt_addr", 32'(bus.wrt_addr), 32'(e.addr));
                chk("wrt_en", 32'(bus.wrt_en), 32'(e.wen));
                chk("latency", 32'(cyc - e.issue), 32'd33);
                chk("busy_at_done", 32'(bus.busy), 32'd0);
                hold_data = e.data;
                hold_addr = e.addr;
            end
        end else begin
            chk("wrt_en_idle", 32'(bus.wrt_en), 32'd0);
            chk("hold_data", bus.wrt_data, hold_data);
            chk("hold_addr", 32'(bus.wrt_addr), 32'(hold_addr));
        end
    end

    // Called at posedge+1; leaves at posedge+1 after the sampling edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit accept);
        exp_t e;
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_addr  = rd;
        if (accept) begin
            e.data  = ref_op(f, a, b);
            e.addr  = rd;
            e.wen   = (rd != 5'd0);
            e.issue = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_addr  = 5'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d results still outstanding after %0d cycles", sb_q.size(), n);
            sb_q.delete();
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t dir[12] = '{
        '{FN_MULH,   32'h8000_0000, 32'h8000_0000},
        '{FN_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{FN_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{FN_DIV,    32'hFFFF_FFF9, 32'd2},
        '{FN_REM,    32'hFFFF_FFF9, 32'd2},
        '{FN_DIVU,   32'd100,       32'd7},
        '{FN_REMU,   32'd100,       32'd7},
        '{FN_DIVU,   32'd5,         32'd0},
        '{FN_REMU,   32'd5,         32'd0},
        '{FN_DIV,    32'h8000_0000, 32'hFFFF_FFFF},
        '{FN_REM,    32'h8000_0000, 32'hFFFF_FFFF},
        '{FN_DIV,    32'd9,         32'd0}
    };

    initial begin
        int n;
        logic [31:0] a, b;
        bus.start    = 1'b0;
        bus.funct3   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_addr  = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wrt_en", 32'(bus.wrt_en), 32'd0);
        chk("rst_wrt_addr", 32'(bus.wrt_addr), 32'd0);
        chk("rst_wrt_data", bus.wrt_data, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        issue(FN_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            issue(dir[i].f, dir[i].a, dir[i].b, 5'(i + 1), 1'b1);
            wait_idle();
        end

        issue(FN_MUL, 32'd3, 32'd4, 5'd0, 1'b1);
        wait_idle();

        // A start nine cycles into an operation must not disturb it.
        issue(FN_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        issue(FN_DIV, 32'd1, 32'd1, 5'd12, 1'b0);
        wait_idle();

        // Start in the done cycle is accepted.
        issue(FN_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait: done not seen after %0d cycles", n);
        end
        issue(FN_REMU, 32'd100, 32'd7, 5'd4, 1'b1);
        wait_idle();

        // Reset mid-operation aborts with no write.
        issue(FN_MUL, 32'd6, 32'd7, 5'd8, 1'b0);
        repeat (11) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_wrt_en", 32'(bus.wrt_en), 32'd0);
        chk("abort_wrt_addr", 32'(bus.wrt_addr), 32'd0);
        chk("abort_wrt_data", bus.wrt_data, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        issue(FN_DIV, 32'd20, 32'd3, 5'd7, 1'b1);
        wait_idle();
        repeat (40) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            issue(3'($urandom), a, b, 5'($urandom), 1'b1);
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule
